// File: rtl/echo_tof_capture.sv
// echo_tof_capture: measures echo time of flight in gclk cycles after a burst start, with blanking, debounce and timeout
module echo_tof_capture #(
    parameter int CNT_W       = 20,
    parameter int BLANK_CYC   = 2400,
    parameter int TIMEOUT_CYC = 600000,
    parameter int DEBOUNCE    = 8
) (
    input  logic             gclk,
    input  logic             rstn,
    input  logic             start,
    input  logic             echo_in,
    output logic             busy,
    output logic [CNT_W-1:0] tof,
    output logic             tof_valid,
    output logic             timeout
);
    localparam int RUN_W = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TIME_END = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] tof_q, tof_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             tof_valid_q, tof_valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             echo_s, accept, expire;

    assign echo_s    = sync_q[1];
    assign busy      = busy_q;
    assign tof       = tof_q;
    assign tof_valid = tof_valid_q;
    assign timeout   = timeout_q;

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            cnt_q       <= '0;
            cand_q      <= '0;
            tof_q       <= '0;
            run_q       <= '0;
            tof_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            tof_q       <= tof_d;
            run_q       <= run_d;
            tof_valid_q <= tof_valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: start restarts from any state; accept beats expiry on the last listen cycle
    always_comb begin
        accept  = state_q == LISTEN && echo_s && run_q == RUN_MAX;
        expire  = state_q == LISTEN && cnt_q == TIME_END && !accept;
        state_d = state_q;
        if (start)
            state_d = BLANK;
        else if (state_q == BLANK && cnt_q == BLANK_END)
            state_d = LISTEN;
        else if (accept || expire)
            state_d = IDLE;
    end

    // Datapath: counter, debounce run, candidate latch and registered result pulses
    always_comb begin
        sync_d      = {sync_q[0], echo_in};
        cnt_d       = start ? '0 : state_q != IDLE ? cnt_q + CNT_W'(1) : cnt_q;
        run_d       = (start || state_q != LISTEN || !echo_s) ? '0 :
                      run_q == RUN_MAX ? run_q : run_q + RUN_W'(1);
        cand_d      = (state_q == LISTEN && echo_s && run_q == '0) ? cnt_q : cand_q;
        tof_valid_d = accept && !start;
        timeout_d   = expire && !start;
        tof_d       = tof_valid_d ? (DEBOUNCE == 1 ? cnt_q : cand_q) : timeout_d ? '1 : tof_q;
        busy_d      = state_d != IDLE;
    end
endmodule

// File: tb/tb_echo_tof_capture.sv
// tb_echo_tof_capture: directed bench comparing two DUTs (debounce 3 and 1) against a streak-based timing model
module tb_echo_tof_capture;
    localparam int B   = 10;
    localparam int TO  = 100;
    localparam int BIG = 1 << 30;
    localparam int DB [2] = '{3, 1};

    logic        gclk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        echo_in = 1'b0;
    logic        busy_w [2];
    logic        tv_w [2];
    logic        to_w [2];
    logic [19:0] tof_w [2];

    int checks = 0;
    int errors = 0;
    int nv [2] = '{0, 0};
    int nt [2] = '{0, 0};

    logic        act [2];
    int          n [2];
    int          st [2];
    logic [19:0] mtof [2];
    logic        mv [2];
    logic        mt [2];
    logic        e1, e2;

    echo_tof_capture #(.CNT_W(20), .BLANK_CYC(B), .TIMEOUT_CYC(TO), .DEBOUNCE(3)) dut0 (
        .gclk(gclk), .rstn(rstn), .start(start), .echo_in(echo_in),
        .busy(busy_w[0]), .tof(tof_w[0]), .tof_valid(tv_w[0]), .timeout(to_w[0])
    );

    echo_tof_capture #(.CNT_W(20), .BLANK_CYC(B), .TIMEOUT_CYC(TO), .DEBOUNCE(1)) dut1 (
        .gclk(gclk), .rstn(rstn), .start(start), .echo_in(echo_in),
        .busy(busy_w[1]), .tof(tof_w[1]), .tof_valid(tv_w[1]), .timeout(to_w[1])
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, a, e);
        end
    endtask

    // One measurement step: cur is the elapsed-count value, s the cnt at which the current high streak began
    function automatic void step(input int d, input logic es, input int cur, input int s_in,
                                 output logic a, output logic t, output int s);
        s = s_in;
        a = 1'b0;
        t = 1'b0;
        if (cur >= B) begin
            if (es) begin
                if (s < 0) s = cur;
                a = (cur - s + 1) >= d;
            end else begin
                s = -1;
            end
            t = !a && cur == TO - 1;
        end
    endfunction

    function automatic logic hi(input int c, input int r1, input int f1, input int r2);
        return (c >= r1 && c <= f1) || c >= r2;
    endfunction

    // Reference model of both DUTs
    always @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            e1 <= 1'b0;
            e2 <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                act[i]  <= 1'b0;
                n[i]    <= 0;
                st[i]   <= -1;
                mtof[i] <= '0;
                mv[i]   <= 1'b0;
                mt[i]   <= 1'b0;
            end
        end else begin
            e1 <= echo_in;
            e2 <= e1;
            for (int i = 0; i < 2; i++) begin
                automatic logic a, t;
                automatic int s;
                if (start) begin
                    act[i] <= 1'b1;
                    n[i]   <= 0;
                    st[i]  <= -1;
                    mv[i]  <= 1'b0;
                    mt[i]  <= 1'b0;
                end else if (act[i]) begin
                    step(DB[i], e2, n[i], st[i], a, t, s);
                    st[i] <= s;
                    n[i]  <= n[i] + 1;
                    mv[i] <= a;
                    mt[i] <= t;
                    if (a) mtof[i] <= 20'(s);
                    else if (t) mtof[i] <= '1;
                    if (a || t) act[i] <= 1'b0;
                end else begin
                    mv[i] <= 1'b0;
                    mt[i] <= 1'b0;
                end
            end
        end
    end

    // Cycle compare on the falling edge
    always @(negedge gclk) begin
        for (int i = 0; i < 2; i++) begin
            chk("busy", i, 32'(busy_w[i]), 32'(act[i]));
            chk("tof", i, 32'(tof_w[i]), 32'(mtof[i]));
            chk("tof_valid", i, 32'(tv_w[i]), 32'(mv[i]));
            chk("timeout", i, 32'(to_w[i]), 32'(mt[i]));
            nv[i] += int'(tv_w[i]);
            nt[i] += int'(to_w[i]);
        end
    end

    task automatic meas(input int r1, input int f1, input int r2, input int rs, input int ncyc);
        @(posedge gclk);
        #1 start = 1'b1;
        echo_in = 1'b0;
        @(posedge gclk);
        #1 start = 1'b0;
        echo_in = hi(1, r1, f1, r2);
        for (int c = 2; c <= ncyc; c++) begin
            @(posedge gclk);
            #1 start = (c == rs);
            echo_in = hi(c, r1, f1, r2);
        end
        @(posedge gclk);
        #1 start = 1'b0;
        echo_in = 1'b0;
        repeat (4) @(posedge gclk);
        #1;
    endtask

    initial begin
        int v0, v1, t0, t1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge gclk);
        chk("reset_tof", 0, 32'(tof_w[0]), 0);
        chk("reset_busy", 0, 32'(busy_w[0]), 0);
        #1 rstn = 1'b1;
        repeat (2) @(posedge gclk);
        #1;

        v0 = nv[0]; t0 = nt[0];
        meas(40, BIG, BIG, 0, 60);
        chk("nominal_tof", 0, 32'(tof_w[0]), 41);
        chk("nominal_tof", 1, 32'(tof_w[1]), 41);
        chk("nominal_valid_cnt", 0, nv[0] - v0, 1);
        chk("nominal_timeout_cnt", 0, nt[0] - t0, 0);

        meas(1, 5, 60, 0, 80);
        chk("blank_ringdown_tof", 0, 32'(tof_w[0]), 61);

        meas(1, BIG, BIG, 0, 40);
        chk("blank_held_tof", 0, 32'(tof_w[0]), 10);
        chk("blank_held_tof", 1, 32'(tof_w[1]), 10);

        v0 = nv[0]; v1 = nv[1];
        meas(30, 31, 50, 0, 70);
        chk("debounce_tof", 0, 32'(tof_w[0]), 51);
        chk("debounce_valid_cnt", 0, nv[0] - v0, 1);
        chk("debounce1_glitch_tof", 1, 32'(tof_w[1]), 31);
        chk("debounce1_valid_cnt", 1, nv[1] - v1, 1);

        v0 = nv[0]; t0 = nt[0]; t1 = nt[1];
        meas(BIG, BIG, BIG, 0, 110);
        chk("timeout_tof", 0, 32'(tof_w[0]), 32'hFFFFF);
        chk("timeout_cnt", 0, nt[0] - t0, 1);
        chk("timeout_cnt", 1, nt[1] - t1, 1);
        chk("timeout_valid_cnt", 0, nv[0] - v0, 0);

        v0 = nv[0]; t0 = nt[0];
        meas(96, BIG, BIG, 0, 110);
        chk("late_accept_tof", 0, 32'(tof_w[0]), 97);
        chk("late_accept_valid_cnt", 0, nv[0] - v0, 1);
        chk("late_accept_timeout_cnt", 0, nt[0] - t0, 0);

        v0 = nv[0];
        meas(16, BIG, BIG, 20, 50);
        chk("restart_tof", 0, 32'(tof_w[0]), 10);
        chk("restart_valid_cnt", 0, nv[0] - v0, 1);

        v0 = nv[0]; t0 = nt[0];
        @(posedge gclk);
        #1 start = 1'b1;
        @(posedge gclk);
        #1 start = 1'b0;
        repeat (24) @(posedge gclk);
        #3 rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 32'(busy_w[i]), 0);
            chk("rst_tof", i, 32'(tof_w[i]), 0);
            chk("rst_valid", i, 32'(tv_w[i]), 0);
            chk("rst_timeout", i, 32'(to_w[i]), 0);
        end
        repeat (3) @(posedge gclk);
        #1 rstn = 1'b1;
        repeat (3) @(posedge gclk);
        #1;
        chk("rst_valid_cnt", 0, nv[0] - v0, 0);
        chk("rst_timeout_cnt", 0, nt[0] - t0, 0);

        meas(35, BIG, BIG, 0, 60);
        chk("post_reset_tof", 0, 32'(tof_w[0]), 36);
        chk("post_reset_valid_cnt", 0, nv[0] - v0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
